// File: rtl/vpu_sequencer.sv
// vpu_sequencer: fetches 24-bit instructions, issues each compute instruction
// to the VPU with a one-cycle clock enable, then copies the VPU result buffer
// back into the 32-word data memory, one word per cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for start; start is only sampled here
// FETCH   | present pc on imem_addr
// DECODE  | instruction word valid; dispatch NOP/HALT/illegal or load VPU bus
// EXEC    | vpu_ce high for exactly this cycle
// CAPTURE | VPU result registers valid; latch dest, load write-back counter
// WRITE   | one result word per cycle into data memory
// DONE    | done pulse, busy falls, back to IDLE
module vpu_sequencer #(
  parameter int NUM_SIZE       = 16,
  parameter int VEC_BUFFER_LEN = 8,
  parameter int PC_WIDTH       = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [PC_WIDTH-1:0]                prog_base,
  output logic [PC_WIDTH-1:0]                imem_addr,
  input  logic [23:0]                        imem_rdata,
  output logic [5:0]                         vpu_opcode,
  output logic [4:0]                         vpu_operand1,
  output logic [4:0]                         vpu_operand2,
  output logic [4:0]                         vpu_operand3,
  output logic [2:0]                         vpu_operand4,
  output logic                               vpu_ce,
  input  logic [NUM_SIZE*VEC_BUFFER_LEN-1:0] vpu_vec_buffer,
  input  logic                               vpu_copy_flag,
  input  logic [4:0]                         vpu_dest,
  input  logic [2:0]                         vpu_length,
  output logic                               mem_we,
  output logic [4:0]                         mem_waddr,
  output logic [NUM_SIZE-1:0]                mem_wdata,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic [PC_WIDTH-1:0]                pc,
  output logic [15:0]                        instr_count
);

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_HALT = 6'd1;
  localparam logic [5:0] OP_ADD  = 6'd2;
  localparam logic [5:0] OP_MOV  = 6'd3;
  localparam logic [5:0] OP_RELU = 6'd4;
  localparam logic [5:0] OP_SCAL = 6'd5;
  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_CAPTURE, S_WRITE, S_DONE
  } state_t;

  state_t     state;
  logic [4:0] dest_q;
  logic [2:0] wr_idx;
  logic [2:0] wr_left;
  logic [5:0] dec_op;

  assign dec_op = imem_rdata[23:18];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Sequencer FSM; every output is a register set on the transition into the
  // state in which it must be visible. wr_left is the write-back down-counter,
  // terminal count at 1 marks the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      pc           <= '0;
      imem_addr    <= '0;
      vpu_opcode   <= '0;
      vpu_operand1 <= '0;
      vpu_operand2 <= '0;
      vpu_operand3 <= '0;
      vpu_operand4 <= '0;
      vpu_ce       <= 1'b0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      instr_count  <= '0;
      dest_q       <= '0;
      wr_idx       <= '0;
      wr_left      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc          <= prog_base;
            error       <= 1'b0;
            instr_count <= '0;
            busy        <= 1'b1;
            state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          imem_addr <= pc;
          state     <= S_DECODE;
        end
        S_DECODE: begin
          case (dec_op)
            OP_NOP: begin
              pc          <= pc + PC_ONE;
              instr_count <= sat_inc(instr_count);
              state       <= S_FETCH;
            end
            OP_HALT: begin
              instr_count <= sat_inc(instr_count);
              done        <= 1'b1;
              state       <= S_DONE;
            end
            OP_ADD, OP_MOV, OP_RELU, OP_SCAL: begin
              vpu_opcode   <= imem_rdata[23:18];
              vpu_operand1 <= imem_rdata[17:13];
              vpu_operand2 <= imem_rdata[12:8];
              vpu_operand3 <= imem_rdata[7:3];
              vpu_operand4 <= imem_rdata[2:0];
              vpu_ce       <= 1'b1;
              state        <= S_EXEC;
            end
            default: begin
              error <= 1'b1;
              done  <= 1'b1;
              state <= S_DONE;
            end
          endcase
        end
        S_EXEC: begin
          vpu_ce <= 1'b0;
          state  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (!vpu_copy_flag) begin
            error <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (vpu_length == 3'd0) begin
            pc          <= pc + PC_ONE;
            instr_count <= sat_inc(instr_count);
            state       <= S_FETCH;
          end else begin
            dest_q    <= vpu_dest;
            mem_we    <= 1'b1;
            mem_waddr <= vpu_dest;
            mem_wdata <= vpu_vec_buffer[0 +: NUM_SIZE];
            wr_idx    <= 3'd1;
            wr_left   <= vpu_length;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (wr_left == 3'd1) begin
            mem_we      <= 1'b0;
            pc          <= pc + PC_ONE;
            instr_count <= sat_inc(instr_count);
            state       <= S_FETCH;
          end else begin
            mem_waddr <= dest_q + {2'b00, wr_idx};
            mem_wdata <= vpu_vec_buffer[32'(wr_idx) * NUM_SIZE +: NUM_SIZE];
            wr_idx    <= wr_idx + 3'd1;
            wr_left   <= wr_left - 3'd1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vpu_sequencer.sv
// Bench for vpu_sequencer: instruction ROM, data memory and a behavioural VPU
// stub around the DUT, plus an instruction-level model that expands each
// program into the expected per-cycle trace of the sequencer outputs.
`timescale 1ns/1ps
module tb_vpu_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start;
  logic [7:0]   prog_base;
  logic [7:0]   imem_addr;
  logic [23:0]  imem_rdata;
  logic [5:0]   vpu_opcode;
  logic [4:0]   vpu_operand1, vpu_operand2, vpu_operand3;
  logic [2:0]   vpu_operand4;
  logic         vpu_ce;
  logic [127:0] vpu_vec_buffer;
  logic         vpu_copy_flag;
  logic [4:0]   vpu_dest;
  logic [2:0]   vpu_length;
  logic         mem_we;
  logic [4:0]   mem_waddr;
  logic [15:0]  mem_wdata;
  logic         busy, done, error;
  logic [7:0]   pc;
  logic [15:0]  instr_count;

  vpu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .prog_base(prog_base),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .vpu_opcode(vpu_opcode), .vpu_operand1(vpu_operand1),
    .vpu_operand2(vpu_operand2), .vpu_operand3(vpu_operand3),
    .vpu_operand4(vpu_operand4), .vpu_ce(vpu_ce),
    .vpu_vec_buffer(vpu_vec_buffer), .vpu_copy_flag(vpu_copy_flag),
    .vpu_dest(vpu_dest), .vpu_length(vpu_length),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .pc(pc), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  localparam logic [23:0] HALT = {6'd1, 18'd0};
  localparam logic [23:0] NOP  = 24'd0;

  int vectors = 0;
  int miscompares = 0;

  logic [23:0] rom [256];
  logic [15:0] dmem [32];
  logic [15:0] ref_mem [32];
  logic        drop_copy;
  logic [23:0] stub_ins;
  logic [127:0] stub_buf;

  assign imem_rdata = rom[imem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // VPU semantics as seen by the environment
  function automatic logic [4:0] dest_of(input logic [23:0] ins);
    if (ins[23:18] == 6'd3 || ins[23:18] == 6'd4) return ins[12:8];
    return ins[7:3];
  endfunction
  function automatic logic [2:0] len_of(input logic [23:0] ins);
    if (ins[23:18] == 6'd3 || ins[23:18] == 6'd4) return ins[5:3];
    return ins[2:0];
  endfunction
  function automatic logic [4:0] addr_a(input logic [23:0] ins, input int k);
    return ins[17:13] + 5'(k);
  endfunction
  function automatic logic [4:0] addr_b(input logic [23:0] ins, input int k);
    if (ins[23:18] == 6'd2) return ins[12:8] + 5'(k);
    return ins[12:8];
  endfunction
  function automatic logic [15:0] vpu_word(input logic [23:0] ins, input logic [15:0] a,
                                           input logic [15:0] b);
    case (ins[23:18])
      6'd2:    return a + b;
      6'd3:    return a;
      6'd4:    return a[15] ? 16'd0 : a;
      6'd5:    return a * b;
      default: return 16'd0;
    endcase
  endfunction

  // Data memory write port and VPU stub (results valid the cycle after vpu_ce)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      vpu_copy_flag  <= 1'b0;
      vpu_dest       <= '0;
      vpu_length     <= '0;
      vpu_vec_buffer <= '0;
    end else begin
      if (mem_we) dmem[mem_waddr] = mem_wdata;
      if (vpu_ce) begin
        stub_ins = {vpu_opcode, vpu_operand1, vpu_operand2, vpu_operand3, vpu_operand4};
        for (int k = 0; k < 8; k++)
          stub_buf[k*16 +: 16] = vpu_word(stub_ins, dmem[addr_a(stub_ins, k)],
                                          dmem[addr_b(stub_ins, k)]);
        vpu_vec_buffer <= stub_buf;
        vpu_copy_flag  <= !drop_copy;
        vpu_dest       <= dest_of(stub_ins);
        vpu_length     <= len_of(stub_ins);
      end
    end
  end

  // Expected per-cycle trace, index 0 = first FETCH cycle after start accepted
  typedef struct packed {
    logic        busy, done, err, ce, we;
    logic [4:0]  waddr;
    logic [15:0] wdata;
    logic [23:0] instr;
  } ev_t;

  ev_t         trace [256];
  int          trace_len;
  int          cyc;
  logic        run_active = 1'b0;
  logic [7:0]  exp_pc;
  logic [15:0] exp_count;
  logic        exp_err;
  int          ce_seen, we_seen, done_idx;

  task automatic push(input logic b, input logic d, input logic e, input logic c,
                      input logic w, input logic [4:0] wa, input logic [15:0] wd,
                      input logic [23:0] in);
    trace[trace_len] = {b, d, e, c, w, wa, wd, in};
    trace_len++;
  endtask

  // Instruction-level execution of the program, expanded by the latency rules:
  // NOP 2 cycles, compute 4+len (ce in 3rd, writes from 5th), HALT/illegal done in 3rd.
  task automatic build_trace(input logic [7:0] base);
    logic [7:0]  p;
    logic [23:0] ins;
    logic [5:0]  op;
    logic [15:0] vals [8];
    logic [4:0]  d;
    logic [2:0]  l;
    logic [15:0] cnt;
    logic        e;
    bit          stop;
    p = base; cnt = 0; e = 0; stop = 0; trace_len = 0;
    for (int n = 0; n < 64 && !stop; n++) begin
      ins = rom[p];
      op  = ins[23:18];
      push(1, 0, 0, 0, 0, 0, 0, 0);
      push(1, 0, 0, 0, 0, 0, 0, 0);
      if (op == 6'd0) begin
        p++;
        if (cnt != 16'hFFFF) cnt++;
      end else if (op == 6'd1) begin
        if (cnt != 16'hFFFF) cnt++;
        push(1, 1, 0, 0, 0, 0, 0, 0);
        stop = 1;
      end else if (op <= 6'd5) begin
        push(1, 0, 0, 1, 0, 0, 0, ins);
        push(1, 0, 0, 0, 0, 0, 0, 0);
        if (drop_copy) begin
          push(1, 1, 1, 0, 0, 0, 0, 0);
          e = 1;
          stop = 1;
        end else begin
          d = dest_of(ins);
          l = len_of(ins);
          for (int k = 0; k < 8; k++)
            vals[k] = vpu_word(ins, ref_mem[addr_a(ins, k)], ref_mem[addr_b(ins, k)]);
          for (int k = 0; k < int'(l); k++) begin
            push(1, 0, 0, 0, 1, d + 5'(k), vals[k], 0);
            ref_mem[d + 5'(k)] = vals[k];
          end
          p++;
          if (cnt != 16'hFFFF) cnt++;
        end
      end else begin
        push(1, 1, 1, 0, 0, 0, 0, 0);
        e = 1;
        stop = 1;
      end
    end
    push(0, 0, e, 0, 0, 0, 0, 0);
    push(0, 0, e, 0, 0, 0, 0, 0);
    exp_pc = p; exp_count = cnt; exp_err = e;
  endtask

  // Compare process: DUT outputs against the expected trace every cycle of a run
  always @(negedge clk) begin
    if (run_active && cyc < trace_len) begin
      chk($sformatf("ctl@%0d", cyc), {27'd0, busy, done, error, vpu_ce, mem_we},
          {27'd0, trace[cyc].busy, trace[cyc].done, trace[cyc].err, trace[cyc].ce, trace[cyc].we});
      if (trace[cyc].we)
        chk($sformatf("wr@%0d", cyc), {11'd0, mem_waddr, mem_wdata},
            {11'd0, trace[cyc].waddr, trace[cyc].wdata});
      if (trace[cyc].ce)
        chk($sformatf("issue@%0d", cyc),
            {8'd0, vpu_opcode, vpu_operand1, vpu_operand2, vpu_operand3, vpu_operand4},
            {8'd0, trace[cyc].instr});
      if (vpu_ce) ce_seen++;
      if (mem_we) we_seen++;
      if (done) done_idx = cyc;
      cyc++;
    end
  end

  task automatic run_prog(input logic [7:0] base);
    build_trace(base);
    @(negedge clk);
    prog_base = base;
    start = 1'b1;
    cyc = 0; ce_seen = 0; we_seen = 0; done_idx = -1;
    @(posedge clk);
    #1 start = 1'b0;
    run_active = 1'b1;
    wait (cyc >= trace_len);
    run_active = 1'b0;
    chk("pc", 32'(pc), 32'(exp_pc));
    chk("instr_count", 32'(instr_count), 32'(exp_count));
    chk("error", 32'(error), 32'(exp_err));
  endtask

  task automatic set_mem(input int a, input logic [15:0] v);
    dmem[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr_pc_cnt"}, {imem_addr, pc, instr_count}, 32'd0);
    chk({tag, "_vpu_bus"}, {8'd0, vpu_opcode, vpu_operand1, vpu_operand2, vpu_operand3,
                            vpu_operand4}, 32'd0);
    chk({tag, "_wr_stat"}, {6'd0, mem_we, mem_waddr, mem_wdata, vpu_ce, busy, done, error},
        32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] base;
    int n;
    start = 1'b0; prog_base = '0; drop_copy = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = NOP;
    for (int i = 0; i < 32; i++) set_mem(i, 16'd0);
    #2 rst = 1'b1;
    #2 chk_reset("por");
    @(negedge clk) rst = 1'b0;

    // MOV 4..6 -> 20..22, then HALT
    rom[8'h10] = {6'd3, 5'd4, 5'd20, 5'd3, 3'd0};
    rom[8'h11] = HALT;
    set_mem(4, 16'd7); set_mem(5, 16'hFFFE); set_mem(6, 16'd9);
    run_prog(8'h10);
    chk("t1_m20", 32'(dmem[20]), 32'h7);
    chk("t1_m21", 32'(dmem[21]), 32'hFFFE);
    chk("t1_m22", 32'(dmem[22]), 32'h9);
    chk("t1_count", 32'(instr_count), 32'd2);
    chk("t1_err", 32'(error), 32'd0);
    chk("t1_done_idx", 32'(done_idx), 32'd9);

    // ADD 0..1 + 8..9 -> 16..17
    rom[8'h30] = {6'd2, 5'd0, 5'd8, 5'd16, 3'd2};
    rom[8'h31] = HALT;
    set_mem(0, 16'd3); set_mem(1, 16'd5); set_mem(8, 16'd4); set_mem(9, 16'hFFFA);
    run_prog(8'h30);
    chk("t2_m16", 32'(dmem[16]), 32'h7);
    chk("t2_m17", 32'(dmem[17]), 32'hFFFF);
    chk("t2_ce_cycles", 32'(ce_seen), 32'd1);

    // RELU with destination wrapping 30,31,0,1
    rom[8'h38] = {6'd4, 5'd0, 5'd30, 5'd4, 3'd0};
    rom[8'h39] = HALT;
    set_mem(0, 16'd5); set_mem(1, 16'h8001); set_mem(2, 16'd0); set_mem(3, 16'h7FFF);
    run_prog(8'h38);
    chk("t3_we_cycles", 32'(we_seen), 32'd4);
    chk("t3_m30", 32'(dmem[30]), 32'h5);
    chk("t3_m31", 32'(dmem[31]), 32'h0);
    chk("t3_m0", 32'(dmem[0]), 32'h0);
    chk("t3_m1", 32'(dmem[1]), 32'h7FFF);

    // NOP, NOP, SCAL len=0, HALT
    rom[8'h20] = NOP; rom[8'h21] = NOP;
    rom[8'h22] = {6'd5, 5'd1, 5'd2, 5'd3, 3'd0};
    rom[8'h23] = HALT;
    run_prog(8'h20);
    chk("t4_we_cycles", 32'(we_seen), 32'd0);
    chk("t4_count", 32'(instr_count), 32'd4);
    chk("t4_done_idx", 32'(done_idx), 32'd10);

    // Illegal opcode 9 at pc=5
    rom[8'h05] = {6'd9, 18'h2AAAA};
    run_prog(8'h05);
    chk("t5_err", 32'(error), 32'd1);
    chk("t5_pc", 32'(pc), 32'd5);
    chk("t5_ce_cycles", 32'(ce_seen), 32'd0);
    chk("t5_done_idx", 32'(done_idx), 32'd2);

    // Missing VPU result
    drop_copy = 1'b1;
    rom[8'h60] = {6'd3, 5'd4, 5'd12, 5'd2, 3'd0};
    rom[8'h61] = HALT;
    run_prog(8'h60);
    chk("t6_err", 32'(error), 32'd1);
    chk("t6_we_cycles", 32'(we_seen), 32'd0);
    chk("t6_count", 32'(instr_count), 32'd0);
    drop_copy = 1'b0;

    // pc wrap 255 -> 0
    rom[8'hFF] = NOP;
    rom[8'h00] = HALT;
    run_prog(8'hFF);
    chk("t7_pc", 32'(pc), 32'd0);
    chk("t7_count", 32'(instr_count), 32'd2);

    // Reset during the 2nd WRITE of a len=5 MOV, then rerun cleanly
    rom[8'h40] = {6'd3, 5'd10, 5'd24, 5'd5, 3'd0};
    rom[8'h41] = HALT;
    for (int i = 0; i < 5; i++) set_mem(10 + i, 16'h0A0A + 16'(i));
    for (int i = 24; i < 29; i++) set_mem(i, 16'd0);
    @(negedge clk);
    prog_base = 8'h40;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    chk("t8_mid_we", 32'(mem_we), 32'd1);
    chk("t8_mid_addr", 32'(mem_waddr), 32'd25);
    rst = 1'b1;
    #1 chk_reset("t8_rst");
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("t8_m24", 32'(dmem[24]), 32'h0A0A);
    chk("t8_m25", 32'(dmem[25]), 32'h0);
    ref_mem[24] = 16'h0A0A;
    run_prog(8'h40);
    chk("t8_m28", 32'(dmem[28]), 32'h0A0E);

    // Randomized programs
    for (int r = 0; r < 25; r++) begin
      base = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        int sel;
        sel = $urandom_range(0, 4);
        rom[base + 8'(i)] = {(sel == 0) ? 6'd0 : 6'(sel + 1), 18'($urandom)};
      end
      rom[base + 8'(n)] = HALT;
      for (int i = 0; i < 32; i++) set_mem(i, 16'($urandom));
      run_prog(base);
      for (int i = 0; i < 32; i++)
        if (dmem[i] !== ref_mem[i]) chk($sformatf("rnd%0d_mem%0d", r, i), 32'(dmem[i]), 32'(ref_mem[i]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vpu_sequencer.md
Name: vpu_sequencer

Overview:
Program sequencer for the vector processing unit. It fetches 24-bit instructions from an instruction memory, decodes them, and drives the VPU opcode/operand bus with a one-cycle clock-enable. It then copies the VPU's vector result buffer back into the 32-word data memory, one word per cycle. It sits between the host start/done handshake, the instruction ROM, the VPU and the data memory write port.

Parameters:
NUM_SIZE, 16, data word width in bits
VEC_BUFFER_LEN, 8, number of VPU result buffer entries
PC_WIDTH, 8, instruction address width

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  begin execution at address prog_base; sampled only in IDLE
prog_base  input  8  first instruction address
imem_addr  output  8  instruction memory address; read data is valid 1 cycle later
imem_rdata  input  24  instruction word {opcode[23:18], op1[17:13], op2[12:8], op3[7:3], op4[2:0]}
vpu_opcode  output  6  opcode to VPU
vpu_operand1  output  5  operand to VPU
vpu_operand2  output  5  operand to VPU
vpu_operand3  output  5  operand to VPU
vpu_operand4  output  3  operand to VPU
vpu_ce  output  1  VPU clock enable, single-cycle pulse per issued instruction
vpu_vec_buffer  input  128  VPU result buffer, entry k at bits [16k+15:16k]
vpu_copy_flag  input  1  VPU result-valid flag
vpu_dest  input  5  VPU destination base address
vpu_length  input  3  VPU number of words to write back
mem_we  output  1  data memory write enable
mem_waddr  output  5  data memory write address
mem_wdata  output  16  data memory write data
busy  output  1  high from the cycle after start is accepted until DONE
done  output  1  one-cycle pulse on HALT
error  output  1  sticky; set on illegal opcode or missing VPU result; cleared by rst or accepted start
pc  output  8  current instruction address
instr_count  output  16  number of retired instructions, including NOP and HALT; cleared on accepted start

Behaviour:
- Reset values (async): state=IDLE, pc=0, imem_addr=0, all vpu_* outputs=0, vpu_ce=0, mem_we=0, mem_waddr=0, mem_wdata=0, busy=0, done=0, error=0, instr_count=0.
- Opcodes:
  - 0: NOP
  - 1: HALT
  - 2: ADD (op1, op2, op3=dest, op4=len)
  - 3: MOV (op1, op2=dest, op3[2:0]=len)
  - 4: RELU (same fields as MOV)
  - 5: SCAL (op1=vec, op2=scalar addr, op3=dest, op4=len)
  - 6-63: illegal.
- States and transitions:
  - IDLE: on start, pc<=prog_base, clear error and instr_count, go to FETCH. start is ignored in every other state.
  - FETCH: imem_addr<=pc; go to DECODE.
  - DECODE: latch imem_rdata.
    - NOP: pc+1, instr_count+1, go to FETCH.
    - HALT: instr_count+1, go to DONE.
    - Illegal: error<=1, go to DONE.
    - Otherwise: drive vpu_* fields, go to EXEC.
  - EXEC: vpu_ce=1 for exactly this cycle; go to CAPTURE.
  - CAPTURE: VPU registers are now valid. If vpu_copy_flag==0, error<=1 and go to DONE. Otherwise latch vpu_dest and vpu_length, set k=0. If length==0, retire the instruction and go to FETCH; else go to WRITE.
  - WRITE: mem_we=1, mem_waddr=(dest+k) mod 32, mem_wdata=entry k; k increments each cycle. After writing k=len-1, retire (pc+1, instr_count+1) and go to FETCH.
  - DONE: done=1 for one cycle, busy<=0, go to IDLE.
- Latency: compute instruction = 4+len cycles; NOP = 2 cycles; HALT to done pulse = 3 cycles after FETCH.
- Write-back of instruction N completes before instruction N+1's EXEC, so the VPU always reads up-to-date memory (no hazards).
- pc wraps 255->0. instr_count saturates at 0xFFFF.
- Destination address wraps modulo 32: dest=30, len=4 writes addresses 30, 31, 0, 1.
- vpu_ce is low in every state except EXEC. The VPU buffer is stable during WRITE, so entries are read directly from vpu_vec_buffer without a copy.
- Reset asserted mid-WRITE: mem_we drops asynchronously and the sequence is abandoned; no partial retire is counted.

Test Plan:
- Program at 0x10 = MOV op1=4, dest=20, len=3; HALT. Memory words 4..6 = 7, -2, 9 -> writes 20=7, 21=0xFFFE, 22=9; done pulses; instr_count=2; error=0.
- ADD op1=0, op2=8, dest=16, len=2 with words 0,1 = 3, 5 and words 8,9 = 4, -6 -> writes 16=7, 17=0xFFFF; vpu_ce high exactly 1 cycle.
- RELU dest=30, len=4 -> writes at 30, 31, 0, 1 in consecutive cycles; mem_we high exactly 4 cycles.
- NOP, NOP, SCAL len=0, HALT -> no mem_we at all; instr_count=4; done 3 cycles after HALT fetch.
- Opcode 9 at pc=5 -> error=1, done pulses, pc stays 5, no vpu_ce.
- Pulse rst during the 2nd WRITE cycle of a len=5 MOV -> all outputs return to reset values immediately; a new start executes the program normally with error=0.
